// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch stage's three handshakes into one bundle.
//   imem request  : imem_req_valid/imem_req_ready/imem_req_addr
//   imem response : imem_resp_valid/imem_resp_data (no backpressure)
//   redirect      : redirect_valid/redirect_pc from execute
//   decoder side  : inst_valid/inst_ready/inst_data/inst_pc
// modport master is the fetch unit's view; modport slave is the
// surrounding memory/decoder/execute view.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the decoder.
// Owns the PC, issues word-aligned requests to instruction memory, pairs
// in-order responses with their request PC and buffers them in a small
// FIFO for the decoder. A redirect flushes the FIFO and arranges for the
// responses still in flight to be discarded.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - fetch_unit_if.master (imem request/response, redirect, decoder)
// Parameters:
//   RESET_PC - PC after reset (word aligned)
//   DEPTH    - FIFO entries and maximum outstanding requests (power of two, >=2)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   pc;

  // Address queue: PCs of accepted requests still waiting for a response.
  logic [31:0]   aq_mem [DEPTH];
  logic [AW-1:0] aq_rd;
  logic [AW-1:0] aq_wr;

  // Instruction FIFO holding {pc, data} for the decoder.
  logic [31:0]   fq_pc   [DEPTH];
  logic [31:0]   fq_data [DEPTH];
  logic [AW-1:0] fq_rd;
  logic [AW-1:0] fq_wr;
  logic [CW-1:0] fq_count;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic          pop;
  logic          req_valid;
  logic          accept;
  logic          resp;
  logic          push;
  logic [SW-1:0] credit_used;

  // A request is only allowed when its response is guaranteed a FIFO slot:
  // buffered entries plus in-flight requests, less the entry leaving now,
  // must stay below DEPTH. This is what makes FIFO overflow impossible.
  assign pop         = (fq_count != '0) & bus.inst_ready;
  assign credit_used = SW'(fq_count) + SW'(outstanding) - SW'(pop);
  assign req_valid   = rst_n & ~bus.redirect_valid & (credit_used < SW'(DEPTH));
  assign accept      = req_valid & bus.imem_req_ready;
  assign resp        = bus.imem_resp_valid;

  // Responses are kept only when no stale responses remain to be skipped and
  // no redirect is flushing the FIFO in this same cycle.
  assign push        = resp & (drop == '0) & ~bus.redirect_valid;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (fq_count != '0);
  assign bus.inst_data      = fq_data[fq_rd];
  assign bus.inst_pc        = fq_pc[fq_rd];

  // Control state: PC, queue pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      aq_rd       <= '0;
      aq_wr       <= '0;
      fq_rd       <= '0;
      fq_wr       <= '0;
      fq_count    <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (accept) aq_wr <= aq_wr + AW'(1);
      // Every response retires its address entry, dropped or not.
      if (resp)   aq_rd <= aq_rd + AW'(1);

      if (bus.redirect_valid) begin
        pc       <= bus.redirect_pc & ~32'd3;
        fq_rd    <= '0;
        fq_wr    <= '0;
        fq_count <= '0;
        // No request is accepted during a redirect, so everything still in
        // flight after this cycle's response must be thrown away.
        drop     <= outstanding - CW'(resp);
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (resp && (drop != '0)) drop <= drop - CW'(1);
        if (push) fq_wr <= fq_wr + AW'(1);
        if (pop)  fq_rd <= fq_rd + AW'(1);
        fq_count <= fq_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      aq_mem[aq_wr] <= pc;
    end
    if (rst_n && push) begin
      fq_pc[fq_wr]   <= aq_mem[aq_rd];
      fq_data[fq_wr] <= bus.imem_resp_data;
    end
  end

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(push && !pop && (fq_count == CW'(DEPTH)))
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the decoder. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready handshake. In-order responses are buffered in a small FIFO together with their PC, and presented to the decoder with a valid/ready handshake. A redirect from execute flushes the FIFO and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2: FIFO entries and maximum outstanding requests; power of two, ≥2.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  request address (current PC).
- imem_resp_valid  in  1  response valid; always accepted, no backpressure.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decoder consumes head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.

## Operation
- State:
  - pc.
  - Address queue (DEPTH entries): PCs of accepted, unanswered requests.
  - Instruction FIFO (DEPTH entries of {pc, data}).
  - outstanding counter, 0..DEPTH.
  - drop counter, 0..DEPTH.
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC; FIFO, address queue, outstanding and drop all cleared.
  - Outputs in the cycle after a reset edge: inst_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC.
  - Reset mid-operation discards everything; later responses to earlier requests are the memory's responsibility, since memory is reset with the core.
- Request issue:
  - imem_req_valid = rst_n & !redirect_valid & (fifo_count + outstanding − pop < DEPTH), where pop = inst_valid & inst_ready.
  - On accept (valid & ready): push pc to the address queue, outstanding+1, pc += 4.
  - pc wraps 32'hFFFF_FFFC → 0.
- Response:
  - Outstanding−1 and pop the address queue.
  - If drop>0: discard the response, drop−1.
  - Otherwise push {queued pc, data} to the FIFO.
  - Overflow is impossible by the credit rule; an assertion must check it.
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle are both performed.
- Redirect (has priority over everything):
  - pc := {redirect_pc[31:2], 2'b00}.
  - FIFO cleared; inst_valid=0 the next cycle. A pop in the redirect cycle is still a legal handshake.
  - drop := outstanding after this cycle's response is accounted. A response arriving in the redirect cycle is itself discarded.
  - No request issued in the redirect cycle; the first request at the new PC is the following cycle.
- inst_data/inst_pc hold stable while inst_valid & !inst_ready.

## Timing
- Request accepted in cycle N with memory latency L≥1 (response in N+L): inst_valid first seen in cycle N+L+1 (FIFO is registered).
- With L=1, DEPTH=2, inst_ready=1, imem_req_ready=1: sustained one instruction per cycle after a 2-cycle startup.
- Redirect in cycle R: first new request in R+1; earliest new instruction at R+1+L+1.
- imem_req_valid is combinational from redirect_valid and inst_ready. All other outputs are registered.

## Test plan
- Reset release with RESET_PC=0x100, L=1, all ready → requests 0x100, 0x104, 0x108 on consecutive cycles; inst_pc sequence 0x100, 0x104, 0x108 with matching data.
- inst_ready=0 for 10 cycles → at most DEPTH requests issued, imem_req_valid=0 afterwards, head stable; on release, streaming resumes with no lost or duplicated PC.
- Redirect to 0x2003 with 2 requests in flight (L=3) → both stale responses dropped; next inst_pc=0x2000; no FIFO entry carries an old PC.
- Response arrives in the same cycle as redirect → that response is dropped and drop counts only the remaining in-flight response; first valid instruction is from the redirect target.
- pc=0xFFFF_FFF8 streaming → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n=0 while inst_valid=1 and 1 request is outstanding → the next cycle inst_valid=0 and imem_req_valid=0; after release, the first request is at RESET_PC.
